mdio_controller: RTL

MDIO_CONTROLLER -- requirements
Module: mdio_controller

---
 rtl/mdio_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mdio_controller.sv
// -----------------------------------------------------------------------------
// mdio_controller
//   Serialises a 32-bit MDIO management frame onto MDC/MDIO_OUT, MSB first.
//   Read frames (OP = 2'b10) hand the line to the PHY for the last 16 bits and
//   capture the returned word. Write frames drive all 32 bits.
//
// Parameters
//   MDC_HALF      CLK cycles per MDC half-period (legal range 1..15)
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       active-low reset, asserts asynchronously, releases synchronously
//   i_mdio_start  level start request, taken in IDLE (or on the DONE exit edge)
//   i_t_data      frame: [31:30] ST, [29:28] OP, [27:23] PHY, [22:18] REG,
//                 [17:16] TA, [15:0] write data
//   i_mdio_in     serial read data from the PHY side
//   o_mdc         management clock
//   o_mdio_out    serial frame bit
//   o_mdio_oe     1 = controller drives MDIO
//   o_mdio_done   one-cycle pulse at the end of every frame
//   o_rd_data     last captured read word
//   o_data_rdy    one-cycle pulse with o_mdio_done, reads only
// -----------------------------------------------------------------------------
module mdio_controller #(
    parameter int MDC_HALF = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mdio_start,
    input  logic [31:0] i_t_data,
    input  logic        i_mdio_in,
    output logic        o_mdc,
    output logic        o_mdio_out,
    output logic        o_mdio_oe,
    output logic        o_mdio_done,
    output logic [15:0] o_rd_data,
    output logic        o_data_rdy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,   // frame bits 0..15
        S_TAIL = 2'd2,   // frame bits 16..31
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(MDC_HALF - 1);

    // Reset synchroniser: assertion passes straight through, release is
    // retimed to i_clk so the FSM never leaves reset on a partial cycle.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_bit;      // current frame bit, 0..31
    logic [3:0]  r_div;      // cycles spent in the current MDC half, 0..MDC_HALF-1
    logic        r_phase;    // 0 = MDC low half, 1 = MDC high half
    logic [31:0] r_shift;    // latched frame, current bit in [31]
    logic        r_is_rd;
    logic [15:0] r_rx;
    logic [15:0] r_rd_data;

    logic w_in_frame;
    logic w_start;
    logic w_half_end;
    logic w_bit_end;

    assign w_in_frame = (r_state == S_SEND) || (r_state == S_TAIL);
    // DONE accepts a start so a held start runs frames back to back with
    // DONE as the only gap cycle.
    assign w_start    = i_mdio_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_half_end = w_in_frame && (r_div == DIV_LAST);
    assign w_bit_end  = w_half_end && r_phase;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_SEND;
            S_SEND: if (w_bit_end && (r_bit == 5'd15)) w_next = S_TAIL;
            S_TAIL: if (w_bit_end && (r_bit == 5'd31)) w_next = S_DONE;
            S_DONE: w_next = w_start ? S_SEND : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit     <= 5'd0;
            r_div     <= 4'd0;
            r_phase   <= 1'b0;
            r_shift   <= 32'd0;
            r_is_rd   <= 1'b0;
            r_rx      <= 16'd0;
            r_rd_data <= 16'd0;
        end else if (w_start) begin
            r_shift <= i_t_data;
            r_is_rd <= (i_t_data[29:28] == 2'b10);
            r_bit   <= 5'd0;
            r_div   <= 4'd0;
            r_phase <= 1'b0;
            r_rx    <= 16'd0;
        end else if (w_in_frame) begin
            if (r_div == DIV_LAST) begin
                r_div   <= 4'd0;
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    // MDC rising edge: sample the PHY during the read tail.
                    if (r_is_rd && r_bit[4])
                        r_rx <= {r_rx[14:0], i_mdio_in};
                end else begin
                    // Bit boundary (MDC falling): advance to the next bit.
                    r_shift <= {r_shift[30:0], 1'b0};
                    if (r_bit == 5'd31) begin
                        r_bit <= 5'd0;
                        // Publish on the edge into DONE so the word is valid
                        // while DATA_RDY is high.
                        if (r_is_rd) r_rd_data <= r_rx;
                    end else begin
                        r_bit <= r_bit + 5'd1;
                    end
                end
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    // ---------------- outputs ----------------
    // All derived from registers that only move on bit boundaries, so OUT/OE
    // are stable across each MDC rising edge.
    assign o_mdc       = w_in_frame && r_phase;
    assign o_mdio_oe   = w_in_frame && !(r_is_rd && r_bit[4]);
    assign o_mdio_out  = o_mdio_oe && r_shift[31];
    assign o_mdio_done = (r_state == S_DONE);
    assign o_data_rdy  = (r_state == S_DONE) && r_is_rd;
    assign o_rd_data   = r_rd_data;

endmodule
